action_table: RTL and testbench

ACTION_TABLE -- requirements
Module: action_table

---
 rtl/action_table_pkg.sv | 26 ++
 rtl/action_table_mem.sv | 25 ++
 rtl/action_table.sv | 143 ++++++++++++++
 tb/tb_action_table.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/action_table_pkg.sv
// Shared encodings for the action table: config opcodes, config FSM states and
// the layout of the default (miss) action word.
package action_table_pkg;

  typedef enum logic [1:0] {
    OP_READ = 2'd0,
    OP_ADD  = 2'd1,
    OP_DEL  = 2'd2,
    OP_RSVD = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StRdWait = 2'd1,
    StRdOut  = 2'd2
  } cfg_state_e;

  localparam int unsigned DefActW     = 120;
  localparam int unsigned DefActLoBit = 93;
  localparam int unsigned DefActHiBit = 95;

  // Two flag bits set, bit 94 between them clear, everything else zero.
  localparam logic [DefActW-1:0] DefaultAction =
      (DefActW'(1) << DefActHiBit) | (DefActW'(1) << DefActLoBit);

endpackage

// File: rtl/action_table_mem.sv
// Simple dual-port storage: one write port, two independent registered read ports.
module action_table_mem #(
  parameter int unsigned AddrW = 6,
  parameter int unsigned DataW = 120
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [DataW-1:0] i_wdata,
  input  logic [AddrW-1:0] i_lk_addr,
  output logic [DataW-1:0] o_lk_data,
  input  logic [AddrW-1:0] i_cfg_addr,
  output logic [DataW-1:0] o_cfg_data
);

  logic [DataW-1:0] r_mem [2**AddrW];

  // Reads return the pre-write contents when address and write collide.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    o_lk_data  <= r_mem[i_lk_addr];
    o_cfg_data <= r_mem[i_cfg_addr];
  end

endmodule

// File: rtl/action_table.sv
// Action lookup table: 3-cycle pipelined lookups with write-first bypass, plus a
// small config FSM for add/del/read of entries.
module action_table
  import action_table_pkg::*;
#(
  parameter int unsigned       DEPTH_BITS     = 6,
  parameter int unsigned       ACT_W          = 120,
  parameter int unsigned       BID_W          = 5,
  parameter logic [ACT_W-1:0]  DEFAULT_ACTION = DefaultAction
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          index_valid,
  input  logic [BID_W+DEPTH_BITS-1:0]   index,
  output logic                          action_valid,
  output logic [BID_W+ACT_W-1:0]        action,
  output logic                          action_hit,
  input  logic                          ruleSet_valid,
  output logic                          ruleSet_ready,
  input  logic [2+ACT_W+DEPTH_BITS-1:0] ruleSet,
  output logic                          result_valid,
  output logic [ACT_W:0]                result
);

  localparam int unsigned Depth = 2**DEPTH_BITS;

  logic [BID_W-1:0]      w_lk_bid;
  logic [DEPTH_BITS-1:0] w_lk_addr;
  logic [1:0]            w_cfg_op;
  logic [ACT_W-1:0]      w_cfg_data;
  logic [DEPTH_BITS-1:0] w_cfg_addr;
  logic                  w_accept, w_add, w_del, w_rd, w_same, w_entry_valid, w_lk_hit;
  logic [ACT_W-1:0]      w_mem_lk_data, w_mem_cfg_data;
  logic                  w_rd_out;
  cfg_state_e            r_state, w_state_next;

  logic [Depth-1:0]      r_valid;
  logic [DEPTH_BITS-1:0] r_cfg_addr;
  logic                  r_s1_valid, r_s1_hit, r_s1_byp;
  logic [BID_W-1:0]      r_s1_bid, r_s2_bid;
  logic [ACT_W-1:0]      r_s1_byp_data, r_s2_data;
  logic                  r_s2_valid, r_s2_hit;

  assign w_lk_bid   = index[BID_W+DEPTH_BITS-1:DEPTH_BITS];
  assign w_lk_addr  = index[DEPTH_BITS-1:0];
  assign w_cfg_op   = ruleSet[2+ACT_W+DEPTH_BITS-1:ACT_W+DEPTH_BITS];
  assign w_cfg_data = ruleSet[ACT_W+DEPTH_BITS-1:DEPTH_BITS];
  assign w_cfg_addr = ruleSet[DEPTH_BITS-1:0];

  assign w_accept = ruleSet_valid & ruleSet_ready;
  assign w_add    = w_accept & (w_cfg_op == OP_ADD);
  assign w_del    = w_accept & (w_cfg_op == OP_DEL);
  assign w_rd     = w_accept & (w_cfg_op == OP_READ);
  assign w_same   = (w_cfg_addr == w_lk_addr);

  // Same-cycle update wins over the stored valid bit.
  assign w_entry_valid = (w_add & w_same) ? 1'b1 :
                         (w_del & w_same) ? 1'b0 : r_valid[w_lk_addr];
  assign w_lk_hit      = w_entry_valid & (w_lk_addr != '1);

  action_table_mem #(
    .AddrW (DEPTH_BITS),
    .DataW (ACT_W)
  ) u_mem (
    .i_clk      (clk),
    .i_we       (w_add),
    .i_waddr    (w_cfg_addr),
    .i_wdata    (w_cfg_data),
    .i_lk_addr  (w_lk_addr),
    .o_lk_data  (w_mem_lk_data),
    .i_cfg_addr (r_cfg_addr),
    .o_cfg_data (w_mem_cfg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else if (w_add) begin
      r_valid[w_cfg_addr] <= 1'b1;
    end else if (w_del) begin
      r_valid[w_cfg_addr] <= 1'b0;
    end
  end

  // Lookup pipeline: stage 1 captures hit/bypass, stage 2 resolves data, stage 3 drives ports.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      action_valid <= 1'b0;
      action       <= '0;
      action_hit   <= 1'b0;
    end else begin
      r_s1_valid   <= index_valid;
      r_s2_valid   <= r_s1_valid;
      action_valid <= r_s2_valid;
      if (r_s2_valid) begin
        action     <= {r_s2_bid, r_s2_data};
        action_hit <= r_s2_hit;
      end
    end
    r_s1_bid      <= w_lk_bid;
    r_s1_hit      <= w_lk_hit;
    r_s1_byp      <= w_add & w_same;
    r_s1_byp_data <= w_cfg_data;
    r_s2_bid      <= r_s1_bid;
    r_s2_hit      <= r_s1_hit;
    r_s2_data     <= !r_s1_hit ? DEFAULT_ACTION :
                     r_s1_byp  ? r_s1_byp_data : w_mem_lk_data;
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:   if (w_rd) w_state_next = StRdWait;
      StRdWait: w_state_next = StRdOut;
      StRdOut:  w_state_next = StIdle;
      default:  w_state_next = StIdle;
    endcase
  end

  always_comb begin
    ruleSet_ready = (r_state == StIdle);
    w_rd_out      = (r_state == StRdOut);
  end

  always_ff @(posedge clk) begin
    if (w_rd) r_cfg_addr <= w_cfg_addr;
    if (reset) begin
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      result_valid <= w_rd_out;
      if (w_rd_out) result <= {r_valid[r_cfg_addr], w_mem_cfg_data};
    end
  end

endmodule

// File: tb/tb_action_table.sv
// Scoreboard bench for action_table: a reference model predicts lookup and read
// responses (value and arrival cycle) at issue time; a negedge monitor compares them.
module tb_action_table;
  import action_table_pkg::*;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         index_valid;
  logic [10:0]  index;
  logic         action_valid;
  logic [124:0] action;
  logic         action_hit;
  logic         ruleSet_valid;
  logic         ruleSet_ready;
  logic [127:0] ruleSet;
  logic         result_valid;
  logic [120:0] result;

  action_table dut (
    .clk           (clk),
    .reset         (reset),
    .index_valid   (index_valid),
    .index         (index),
    .action_valid  (action_valid),
    .action        (action),
    .action_hit    (action_hit),
    .ruleSet_valid (ruleSet_valid),
    .ruleSet_ready (ruleSet_ready),
    .ruleSet       (ruleSet),
    .result_valid  (result_valid),
    .result        (result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [124:0] act; logic hit; int cyc; } lk_exp_t;
  typedef struct { logic [120:0] res; int cyc; } rd_exp_t;

  localparam logic [119:0] ExpDefault = {24'b0, 1'b1, 1'b0, 1'b1, 93'b0};

  lk_exp_t      lk_q[$];
  rd_exp_t      rd_q[$];
  int           n_checks = 0;
  int           n_pass = 0;
  logic [119:0] m_data [64];
  bit           m_valid [64];
  int           m_busy = 0;
  bit           seen_rst = 1'b0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
  endtask

  always @(negedge clk) begin
    lk_exp_t e;
    rd_exp_t r;
    if (!reset) begin
      if (lk_q.size() != 0 && lk_q[0].cyc < cyc) begin
        check_eq("lk_missing", 128'(0), 128'(1));
        void'(lk_q.pop_front());
      end
      if (action_valid) begin
        if (lk_q.size() == 0) check_eq("lk_unexpected", 128'(1), 128'(0));
        else begin
          e = lk_q.pop_front();
          check_eq("lk_cycle", 128'(cyc), 128'(e.cyc));
          check_eq("lk_action", 128'(action), 128'(e.act));
          check_eq("lk_hit", 128'(action_hit), 128'(e.hit));
        end
      end
      if (rd_q.size() != 0 && rd_q[0].cyc < cyc) begin
        check_eq("rd_missing", 128'(0), 128'(1));
        void'(rd_q.pop_front());
      end
      if (result_valid) begin
        if (rd_q.size() == 0) check_eq("rd_unexpected", 128'(1), 128'(0));
        else begin
          r = rd_q.pop_front();
          check_eq("rd_cycle", 128'(cyc), 128'(r.cyc));
          check_eq("rd_result", 128'(result), 128'(r.res));
        end
      end
    end
  end

  // One clock of stimulus; updates the model in commit order (config before lookup).
  task automatic step(input bit rst, input bit lv, input logic [4:0] bid, input logic [5:0] la,
                      input bit cv, input logic [1:0] op, input logic [119:0] d,
                      input logic [5:0] ca);
    bit      acc;
    lk_exp_t e;
    rd_exp_t r;
    @(posedge clk);
    #1;
    reset         = rst;
    index_valid   = lv;
    index         = {bid, la};
    ruleSet_valid = cv;
    ruleSet       = {op, d, ca};
    #1;
    if (seen_rst) check_eq("ready", 128'(ruleSet_ready), 128'(m_busy == 0));
    acc = cv && !rst && (m_busy == 0);
    if (m_busy > 0) m_busy--;
    if (rst) begin
      m_valid  = '{default: 1'b0};
      lk_q.delete();
      rd_q.delete();
      m_busy   = 0;
      seen_rst = 1'b1;
      return;
    end
    if (acc) begin
      if (op == OP_ADD) begin
        m_data[ca]  = d;
        m_valid[ca] = 1'b1;
      end else if (op == OP_DEL) begin
        m_valid[ca] = 1'b0;
      end else if (op == OP_READ) begin
        m_busy = 2;
        r.res  = {m_valid[ca], m_data[ca]};
        r.cyc  = cyc + 3;
        rd_q.push_back(r);
      end
    end
    if (lv) begin
      e.hit = m_valid[la] && (la != 6'd63);
      e.act = {bid, e.hit ? m_data[la] : ExpDefault};
      e.cyc = cyc + 3;
      lk_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 5'd0, 6'd0, 0, 2'd0, 120'd0, 6'd0);
  endtask

  initial begin
    index_valid   = 1'b0;
    index         = '0;
    ruleSet_valid = 1'b0;
    ruleSet       = '0;

    step(1, 0, 5'd0, 6'd0, 0, 2'd0, 120'd0, 6'd0);
    step(1, 0, 5'd0, 6'd0, 0, 2'd0, 120'd0, 6'd0);
    idle(1);
    check_eq("rst_action_valid", 128'(action_valid), 128'(0));
    check_eq("rst_action", 128'(action), 128'(0));
    check_eq("rst_action_hit", 128'(action_hit), 128'(0));
    check_eq("rst_result_valid", 128'(result_valid), 128'(0));
    check_eq("rst_result", 128'(result), 128'(0));

    step(0, 0, 5'd0, 6'd0,  1, OP_ADD, 120'hA5, 6'd5);
    step(0, 1, 5'd3, 6'd5,  0, OP_READ, 120'd0, 6'd0);
    step(0, 1, 5'd1, 6'd63, 1, OP_ADD, 120'h77, 6'd63);
    step(0, 1, 5'd2, 6'd7,  0, OP_READ, 120'd0, 6'd0);
    step(0, 0, 5'd0, 6'd0,  1, OP_ADD, 120'h11, 6'd9);
    step(0, 1, 5'd6, 6'd9,  1, OP_ADD, 120'h22, 6'd9);
    step(0, 1, 5'd7, 6'd9,  1, OP_DEL, 120'h0, 6'd9);
    step(0, 1, 5'd8, 6'd9,  0, OP_READ, 120'd0, 6'd0);
    step(0, 1, 5'd9, 6'd5,  1, OP_RSVD, 120'h0, 6'd5);

    // Read held valid back-to-back: second request waits for ready.
    repeat (4) step(0, 0, 5'd0, 6'd0, 1, OP_READ, 120'd0, 6'd9);
    idle(3);
    step(0, 1, 5'd4, 6'd5, 1, OP_READ, 120'd0, 6'd5);
    idle(3);
    step(0, 0, 5'd0,  6'd0,  1, OP_ADD, 120'h5A, 6'd5);
    step(0, 0, 5'd0,  6'd0,  1, OP_DEL, 120'h0, 6'd20);
    step(0, 1, 5'd10, 6'd5,  0, OP_READ, 120'd0, 6'd0);
    step(0, 1, 5'd11, 6'd20, 0, OP_READ, 120'd0, 6'd0);
    idle(4);

    // Eight back-to-back lookups; reset lands on the cycle of the fifth response.
    for (int i = 0; i < 8; i++) begin
      step((i == 7), 1, (i % 2) ? 5'd21 : 5'd10, (i % 2) ? 6'd5 : 6'd7,
           0, OP_READ, 120'd0, 6'd0);
    end
    idle(6);
    step(0, 1, 5'd1, 6'd5, 0, OP_READ, 120'd0, 6'd0);
    step(0, 0, 5'd0, 6'd0, 1, OP_ADD, 120'h33, 6'd5);
    step(0, 1, 5'd2, 6'd5, 0, OP_READ, 120'd0, 6'd0);

    for (int i = 0; i < 20 && (lk_q.size() != 0 || rd_q.size() != 0); i++) idle(1);
    idle(2);
    check_eq("lk_queue_drained", 128'(lk_q.size()), 128'(0));
    check_eq("rd_queue_drained", 128'(rd_q.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
